// File: rtl/tcoordgen.sv
// Texture coordinate generator: walks a destination frame in raster order and
// emits, per pixel, the destination coordinate and its zoomed/translated source.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   hres, vres        frame size, latched on an accepted start
//   zoom              unsigned Q1.8 scale, latched on an accepted start
//   dx, dy            signed source translation, latched on an accepted start
//   start             frame request, ignored while busy
//   busy              frame in progress
//   td_x, td_y        destination coordinate
//   ts_x, ts_y        source coordinate
//   t_ready, t_next   valid/accept handshake for the coordinate set
module tcoordgen #(
    parameter int ZOOM_FRAC = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hres,
    input  logic [10:0] vres,
    input  logic [8:0]  zoom,
    input  logic [10:0] dx,
    input  logic [10:0] dy,
    input  logic        start,
    output logic        busy,
    output logic [10:0] td_x,
    output logic [10:0] td_y,
    output logic [10:0] ts_x,
    output logic [10:0] ts_y,
    output logic        t_ready,
    input  logic        t_next
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        t_ready_q, t_ready_d;
    logic [10:0] td_x_q, td_x_d;
    logic [10:0] td_y_q, td_y_d;
    logic [10:0] ts_x_q, ts_x_d;
    logic [10:0] ts_y_q, ts_y_d;
    logic [10:0] hres_q, hres_d;
    logic [10:0] vres_q, vres_d;
    logic [8:0]  zoom_q, zoom_d;
    logic [10:0] dx_q, dx_d;
    logic [10:0] dy_q, dy_d;

    logic        last_px;
    logic [10:0] nx, ny;

    // Source coordinate for one axis: c + d + floor((t - c) * z / 2^ZOOM_FRAC),
    // wrapped to 11 bits. 24-bit signed keeps the product exact.
    function automatic logic [10:0] map_coord(
        input logic [10:0] t,
        input logic [10:0] res,
        input logic [10:0] d,
        input logic [8:0]  z
    );
        logic signed [23:0] c;
        logic signed [23:0] diff;
        logic signed [23:0] prod;
        logic signed [23:0] sum;
        c    = $signed({13'd0, res >> 1});
        diff = $signed({13'd0, t}) - c;
        prod = diff * $signed({15'd0, z});
        sum  = c + $signed({{13{d[10]}}, d}) + (prod >>> ZOOM_FRAC);
        return sum[10:0];
    endfunction

    always_comb begin
        last_px = (td_x_q == hres_q - 11'd1) && (td_y_q == vres_q - 11'd1);
        if (td_x_q == hres_q - 11'd1) begin
            nx = 11'd0;
            ny = td_y_q + 11'd1;
        end else begin
            nx = td_x_q + 11'd1;
            ny = td_y_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        t_ready_d = t_ready_q;
        td_x_d    = td_x_q;
        td_y_d    = td_y_q;
        ts_x_d    = ts_x_q;
        ts_y_d    = ts_y_q;
        hres_d    = hres_q;
        vres_d    = vres_q;
        zoom_d    = zoom_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        unique case (state_q)
            S_IDLE: begin
                // busy set while idle only happens for an empty frame:
                // drop it after one cycle.
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (start) begin
                    busy_d = 1'b1;
                    if (hres != 11'd0 && vres != 11'd0) begin
                        hres_d  = hres;
                        vres_d  = vres;
                        zoom_d  = zoom;
                        dx_d    = dx;
                        dy_d    = dy;
                        td_x_d  = 11'd0;
                        td_y_d  = 11'd0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                ts_x_d    = map_coord(11'd0, hres_q, dx_q, zoom_q);
                ts_y_d    = map_coord(11'd0, vres_q, dy_q, zoom_q);
                t_ready_d = 1'b1;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (t_next) begin
                    if (last_px) begin
                        t_ready_d = 1'b0;
                        busy_d    = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        td_x_d = nx;
                        td_y_d = ny;
                        ts_x_d = map_coord(nx, hres_q, dx_q, zoom_q);
                        ts_y_d = map_coord(ny, vres_q, dy_q, zoom_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            t_ready_q <= 1'b0;
            td_x_q    <= 11'd0;
            td_y_q    <= 11'd0;
            ts_x_q    <= 11'd0;
            ts_y_q    <= 11'd0;
            hres_q    <= 11'd0;
            vres_q    <= 11'd0;
            zoom_q    <= 9'd0;
            dx_q      <= 11'd0;
            dy_q      <= 11'd0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            t_ready_q <= t_ready_d;
            td_x_q    <= td_x_d;
            td_y_q    <= td_y_d;
            ts_x_q    <= ts_x_d;
            ts_y_q    <= ts_y_d;
            hres_q    <= hres_d;
            vres_q    <= vres_d;
            zoom_q    <= zoom_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
        end
    end

    assign busy    = busy_q;
    assign t_ready = t_ready_q;
    assign td_x    = td_x_q;
    assign td_y    = td_y_q;
    assign ts_x    = ts_x_q;
    assign ts_y    = ts_y_q;

endmodule

// File: tb/tb_tcoordgen.sv
// Bench for tcoordgen: constant vectors, random frames against an
// arithmetic reference model, and hand sequences for handshake/reset cases.
module tb_tcoordgen;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hres, vres, dx, dy;
    logic [8:0]  zoom;
    logic        start, t_next;
    logic        busy, t_ready;
    logic [10:0] td_x, td_y, ts_x, ts_y;

    int passed = 0;
    int total  = 0;

    tcoordgen dut (
        .clk    (clk),
        .rst    (rst),
        .hres   (hres),
        .vres   (vres),
        .zoom   (zoom),
        .dx     (dx),
        .dy     (dy),
        .start  (start),
        .busy   (busy),
        .td_x   (td_x),
        .td_y   (td_y),
        .ts_x   (ts_x),
        .ts_y   (ts_y),
        .t_ready(t_ready),
        .t_next (t_next)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h, v, z, ddx, ddy;
        int px, py;
        int ex, ey;
    } vec_t;

    function automatic bit check(input string name,
                                 input logic [63:0] got,
                                 input logic [63:0] exp);
        total++;
        if (got === exp) begin
            passed++;
            return 1'b1;
        end
        $display("FAIL %s: got %h expected %h", name, got, exp);
        return 1'b0;
    endfunction

    // floor((t-c)*z/256) written with plain integer division
    function automatic int model_ts(int t, int res, int d, int z);
        int c, p, q, v;
        c = res / 2;
        p = (t - c) * z;
        if (p >= 0) q = p / 256;
        else        q = -((-p + 255) / 256);
        v = c + d + q;
        return ((v % 2048) + 2048) % 2048;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        t_next = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic junk_params();
        hres = 11'($urandom);
        vres = 11'($urandom);
        zoom = 9'($urandom);
        dx   = 11'($urandom);
        dy   = 11'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns after the LOAD edge.
    task automatic start_frame(int h, int v, int z, int ddx, int ddy);
        bit ok;
        hres  = h[10:0];
        vres  = v[10:0];
        zoom  = z[8:0];
        dx    = ddx[10:0];
        dy    = ddy[10:0];
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ok = check("load_busy_noready", {62'd0, busy, t_ready}, 64'd2);
        junk_params();
        @(posedge clk);
        @(negedge clk);
    endtask

    // mode 0: t_next=1 always; 1: random t_next; 2: stall 3 cycles at pixel 3
    task automatic run_frame(int h, int v, int z, int ddx, int ddy,
                             int mode, int maxpix);
        logic [43:0] exp_q[$];
        int n, lim, k, cycles, budget, stall;
        bit ok, rdy, tn;
        n   = h * v;
        lim = (n < maxpix) ? n : maxpix;
        for (int p = 0; p < lim; p++) begin
            int x, y;
            x = p % h;
            y = p / h;
            exp_q.push_back({x[10:0], y[10:0],
                             11'(model_ts(x, h, ddx, z)),
                             11'(model_ts(y, v, ddy, z))});
        end
        start_frame(h, v, z, ddx, ddy);
        k = 0;
        cycles = 0;
        stall = 0;
        budget = lim * 12 + 20;
        while (k < lim && cycles < budget) begin
            ok = check("pixel", {20'd0, t_ready, td_x, td_y, ts_x, ts_y},
                       {20'd0, 1'b1, exp_q[k]});
            if (!ok) begin
                $display("  at pixel %0d of %0dx%0d", k, h, v);
                break;
            end
            rdy = t_ready;
            if (mode == 1) begin
                tn = 1'($urandom_range(0, 1));
            end else if (mode == 2 && k == 3 && stall < 3) begin
                tn = 1'b0;
                stall++;
            end else begin
                tn = 1'b1;
            end
            t_next = tn;
            // starts while busy must be ignored
            start = 1'($urandom_range(0, 1));
            junk_params();
            @(posedge clk);
            if (rdy && tn) k++;
            @(negedge clk);
            cycles++;
        end
        start  = 1'b0;
        t_next = 1'b0;
        ok = check("pixels_done", 64'(k), 64'(lim));
        if (lim == n) begin
            ok = check("end_idle", {62'd0, busy, t_ready}, 64'd0);
            if (mode == 0)
                ok = check("consecutive", 64'(cycles), 64'(n));
            if (mode == 2)
                ok = check("stall_cycles", 64'(cycles), 64'(n + 3));
            @(posedge clk);
            @(negedge clk);
            ok = check("stay_idle", {62'd0, busy, t_ready}, 64'd0);
        end else begin
            do_reset();
        end
    endtask

    task automatic zero_frame(int h, int v);
        bit ok;
        hres  = h[10:0];
        vres  = v[10:0];
        zoom  = 9'd256;
        dx    = 11'd0;
        dy    = 11'd0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ok = check("zero_busy", {62'd0, busy, t_ready}, 64'd2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            ok = check("zero_idle", {62'd0, busy, t_ready}, 64'd0);
        end
    endtask

    vec_t vecs[10];

    initial begin
        bit ok;
        vecs[0] = '{4, 2, 256, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{4, 2, 256, 0, 0, 3, 1, 3, 1};
        vecs[2] = '{640, 480, 128, 0, 0, 0, 0, 160, 120};
        vecs[3] = '{640, 2, 128, 0, 0, 639, 1, 479, 1};
        vecs[4] = '{2, 480, 128, 0, 0, 1, 479, 1, 359};
        vecs[5] = '{640, 480, 256, -5, 3, 0, 0, 2043, 3};
        vecs[6] = '{640, 480, 256, -5, 3, 10, 0, 5, 3};
        vecs[7] = '{8, 8, 0, 0, 0, 7, 7, 4, 4};
        vecs[8] = '{8, 4, 511, 0, 0, 0, 0, 2044, 2046};
        vecs[9] = '{4, 2, 256, 1023, -1024, 3, 1, 1026, 1025};

        rst = 1'b1;
        start = 1'b0;
        t_next = 1'b0;
        hres = 11'd0;
        vres = 11'd0;
        zoom = 9'd0;
        dx = 11'd0;
        dy = 11'd0;
        #1;
        ok = check("reset_outs",
                   {18'd0, busy, t_ready, td_x, td_y, ts_x, ts_y}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // constant vectors
        for (int i = 0; i < 10; i++) begin
            int cyc;
            start_frame(vecs[i].h, vecs[i].v, vecs[i].z,
                        vecs[i].ddx, vecs[i].ddy);
            t_next = 1'b1;
            cyc = 0;
            while (!(t_ready && td_x == vecs[i].px[10:0]
                     && td_y == vecs[i].py[10:0])
                   && cyc < vecs[i].h * vecs[i].v + 10) begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
            ok = check($sformatf("vec%0d_ts", i), {42'd0, ts_x, ts_y},
                       {42'd0, vecs[i].ex[10:0], vecs[i].ey[10:0]});
            do_reset();
        end

        // 4x2 unity frame, one transfer per clock, ignored starts
        run_frame(4, 2, 256, 0, 0, 0, 100);
        // stall three cycles mid-frame
        run_frame(5, 3, 200, 7, -9, 2, 100);
        // empty frames
        zero_frame(0, 5);
        zero_frame(7, 0);

        // reset at transfer 5 of a 4x2 frame
        start_frame(4, 2, 256, 0, 0);
        t_next = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        ok = check("pre_rst_pixel", {42'd0, td_x, td_y}, {42'd0, 11'd0, 11'd1});
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        ok = check("rst_async",
                   {18'd0, busy, t_ready, td_x, td_y, ts_x, ts_y}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            ok = check("post_rst_idle", {62'd0, busy, t_ready}, 64'd0);
        end
        t_next = 1'b0;
        run_frame(4, 2, 256, 0, 0, 0, 100);

        // random frames against the model
        for (int i = 0; i < 12; i++) begin
            int h, v, z, ddx, ddy;
            if (i % 2 == 1) begin
                h = $urandom_range(1, 9);
                v = $urandom_range(1, 5);
            end else begin
                h = $urandom_range(1, 2047);
                v = $urandom_range(1, 2047);
            end
            z   = $urandom_range(0, 511);
            ddx = int'($urandom_range(0, 2047)) - 1024;
            ddy = int'($urandom_range(0, 2047)) - 1024;
            run_frame(h, v, z, ddx, ddy, 1, 40);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tcoordgen.md
TCOORDGEN -- requirements
Module: tcoordgen

Interface
REQ-001 Parameter ZOOM_FRAC, default 8: fractional bits of zoom; 256 = 1.0.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 hres, vres  input  11 each  frame width/height; sampled only at frame start.
REQ-005 zoom  input  9  unsigned Q1.8 scale factor; sampled at frame start.
REQ-006 dx, dy  input  11 each  signed two's-complement source translation; sampled at frame start.
REQ-007 start  input  1  frame-start request; honoured only when busy=0.
REQ-008 busy  output  1  high from the accepted start until the edge after the last transfer.
REQ-009 td_x, td_y  output  11 each  destination pixel coordinate (registered).
REQ-010 ts_x, ts_y  output  11 each  source pixel coordinate (registered).
REQ-011 t_ready  output  1  coordinate set valid.
REQ-012 t_next  input  1  consumer accepts the current set; transfer = t_ready & t_next at a rising edge.

Function
REQ-013 States: IDLE, LOAD, RUN.
REQ-014 IDLE: start=1 and hres!=0 and vres!=0 -> latch hres/vres/zoom/dx/dy, clear counters, busy<=1, go to LOAD.
REQ-015 IDLE: start=1 with hres=0 or vres=0 -> busy<=1 for exactly one cycle, then back to IDLE; t_ready stays 0.
REQ-016 LOAD: register coordinates for (0,0), t_ready<=1, go to RUN; first t_ready is 2 edges after start sampled.
REQ-017 RUN: outputs and t_ready held stable while t_next=0.
REQ-018 RUN, transfer, not last pixel: register next pixel's coordinates on the same edge and keep t_ready=1, giving one transfer per clock.
REQ-019 Raster order: x from 0 to hres-1; at x=hres-1, x wraps to 0 and y increments.
REQ-020 Last pixel is (hres-1, vres-1); its transfer sets t_ready<=0 and busy<=0, and the state returns to IDLE.
REQ-021 start while busy=1 is ignored; latched parameters do not change mid-frame.
REQ-022 td_x, td_y = current counters.
REQ-023 Centre: cx = hres>>1, cy = vres>>1, using the latched values.
REQ-024 ts_x = cx + dx + ((td_x - cx)*zoom >>> ZOOM_FRAC); ts_y is the same form using td_y, cy, dy.
REQ-025 Arithmetic: signed, at least 22 bits wide; the shift is arithmetic (floor toward minus infinity); the result is truncated to its low 11 bits.
REQ-026 Truncation wraps negative or oversize results modulo 2048; no saturation or clipping is done here, and out-of-range rejection is the downstream boundary check's job.
REQ-027 Parameter inputs changing outside frame start have no effect on the outputs.

Reset
REQ-028 rst=1 forces, asynchronously, state=IDLE, busy=0, t_ready=0, all coordinate outputs=0, counters=0 and latched parameters=0.
REQ-029 rst asserted mid-frame abandons the frame; after release the block waits in IDLE for a new start, and no stale t_ready appears.

Verification
REQ-030 hres=4, vres=2, zoom=256, dx=dy=0, t_next tied to 1, start pulse -> exactly 8 transfers on consecutive cycles, td=(0,0),(1,0),(2,0),(3,0),(0,1)..(3,1), ts=td each time; busy falls the edge after the 8th transfer.
REQ-031 hres=640, vres=480, zoom=128, dx=dy=0 -> first ts=(160,120); at td=(639,479), ts=(479,359).
REQ-032 hres=640, vres=480, zoom=256, dx=-5, dy=3 -> td=(0,0) gives ts=(2043,3); td=(10,0) gives ts=(5,3).
REQ-033 t_next held 0 for 3 cycles mid-frame -> t_ready, td and ts unchanged across those cycles; after t_next=1, the next pixel appears on the following edge, with none skipped or duplicated.
REQ-034 rst pulsed at transfer 5 of a 4x2 frame -> all outputs 0 immediately; after a new start, the sequence restarts at td=(0,0).
REQ-035 start with hres=0 -> busy high for one cycle, t_ready never asserted; a start asserted during busy in REQ-030 -> no extra transfers.
